riscv_mc_ctrl: RTL and testbench
================================

# riscv_mc_ctrl

Multi-cycle sequencing controller for the RISC-V core datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the datapath strobes: PC update, IR load, register-file write and memory requests. Memory access uses a req/ready handshake on a single shared port. It sits beside Decode: Decode supplies the per-instruction ALU and immediate controls, and this block decides *when* each of them takes effect.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  allows a new fetch; sampled only in FETCH
- opcode  in  7  IR[6:0] from the instruction register
- br_taken  in  1  branch condition from the ALU comparator; valid in EXEC
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write request (store); valid with mem_req
- mem_sel_data  out  1  0 = address from PC (fetch), 1 = address from ALU result (data)
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  load PC this cycle
- pc_src  out  2  0 = PC+4, 1 = PC+offset (branch/jal), 2 = (rs1+imm)&~1 (jalr)
- reg_write  out  1  register-file write strobe
- mem_to_reg  out  1  write-back data from memory (1) or ALU/link (0)
- illegal  out  1  sticky unsupported-opcode flag
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ILL=7
- retired  out  CNT_W  count of completed instructions

## Operation
- Reset (asynchronous, rst_n=0): state=FETCH. All strobes, illegal and retired go to 0. Asserting reset mid-instruction abandons the instruction, including any outstanding memory access.
- FETCH: if run=0, stay in FETCH with all strobes 0. If run=1, drive mem_req=1, mem_sel_data=0 and mem_we=0, holding them until mem_ready. In the mem_ready cycle, ir_write=1 and next=DECODE.
- DECODE: one cycle with no strobes. Recognised opcodes go to EXEC: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui, 0010111 auipc. Any other opcode goes to ILL.
- EXEC:
  - branch: pc_write=1, pc_src = br_taken ? 1 : 0; retire; next FETCH.
  - jal: reg_write=1, mem_to_reg=0, pc_write=1, pc_src=1; retire; next FETCH.
  - jalr: same as jal but pc_src=2.
  - load/store: next MEM.
  - R, I-ALU, lui, auipc: next WB.
- MEM: mem_req=1, mem_sel_data=1, mem_we=1 for store. Hold until mem_ready. In the mem_ready cycle, a store does pc_write=1, pc_src=0, retires and goes to FETCH; a load goes to WB.
- WB: reg_write=1, mem_to_reg=1 for a load (0 otherwise), pc_write=1, pc_src=0; retire; next FETCH.
- Retire means retired increments by 1 on the clock edge that leaves the retiring state. It wraps modulo 2^CNT_W.
- ILL: illegal=1, all strobes 0, no exit except reset.
- Strobes are Moore/Mealy outputs derived from state plus the current inputs (mem_ready, br_taken, opcode). They are never asserted outside the states listed above.

## Timing
- Latency with mem_ready already high in the request cycle (zero wait):
  - branch/jal/jalr: 3 cycles
  - R/I/lui/auipc/store: 4 cycles
  - load: 5 cycles
- Each wait cycle on mem_ready adds exactly one cycle. During a wait, mem_req, mem_we and mem_sel_data hold steady.
- A request once raised is never withdrawn before mem_ready, even if run falls.
- pc_write, ir_write and reg_write are single-cycle pulses, exactly one of each per instruction, except:
  - ir_write: only in FETCH;
  - reg_write: none for branch/store.
- run is ignored outside FETCH. Deasserting it mid-instruction lets the instruction complete, then the block idles in FETCH.
- A mem_ready pulse seen while mem_req=0 is ignored.

## Test plan
- Reset: hold rst_n=0 mid-MEM of a load → state=0, mem_req=0, retired=0 asynchronously, before the next clock edge. Release with run=1 → fetch restarts.
- Zero-wait sequence lui, addi, add, sw, lw, beq(taken) with mem_ready=1 → state traces 0-1-2-4, 0-1-2-4, 0-1-2-4, 0-1-2-3, 0-1-2-3-4, 0-1-2. retired=6 after 24 cycles; beq shows pc_src=1.
- Fetch waits: mem_ready low for 3 cycles during FETCH of 0x02000fe7 (jalr) → mem_req high for 4 cycles, ir_write pulse only in the ready cycle, then one EXEC cycle with reg_write=1, pc_write=1, pc_src=2.
- Branch not taken: 0x00001c63 (bne) with br_taken=0 → pc_src=0, pc_write=1, no reg_write.
- Store with 2 wait states: 0x001c2623 → mem_we=1, mem_sel_data=1 for 3 cycles, no reg_write, retired+1.
- Illegal opcode 0x0000007f → state=7, illegal=1 and stays there, with run and mem_ready toggling; only rst_n clears it.

Source files
------------

// File: rtl/riscv_mc_ctrl_if.sv
// riscv_mc_ctrl_if: sequencing-controller bundle between the control FSM and the datapath/memory side.
interface riscv_mc_ctrl_if #(parameter int CNT_W = 32);
  logic             run;
  logic [6:0]       opcode;
  logic             br_taken;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             mem_sel_data;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic             mem_to_reg;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  modport master (
    input  run, opcode, br_taken, mem_ready,
    output mem_req, mem_we, mem_sel_data, ir_write, pc_write, pc_src,
           reg_write, mem_to_reg, illegal, state, retired
  );
  modport slave (
    output run, opcode, br_taken, mem_ready,
    input  mem_req, mem_we, mem_sel_data, ir_write, pc_write, pc_src,
           reg_write, mem_to_reg, illegal, state, retired
  );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath strobes and a shared memory port.
module riscv_mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  riscv_mc_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ILL    = 3'd7
  } state_e;
  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             fetch_req;
  logic             is_br, is_jal, is_jalr, is_ld, is_st, is_alu, legal;
  assign is_br   = bus.opcode == 7'b1100011;
  assign is_jal  = bus.opcode == 7'b1101111;
  assign is_jalr = bus.opcode == 7'b1100111;
  assign is_ld   = bus.opcode == 7'b0000011;
  assign is_st   = bus.opcode == 7'b0100011;
  assign is_alu  = bus.opcode == 7'b0110011 || bus.opcode == 7'b0010011 ||
                   bus.opcode == 7'b0110111 || bus.opcode == 7'b0010111;
  assign legal   = is_br || is_jal || is_jalr || is_ld || is_st || is_alu;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pend_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      retired_q <= retired_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    pend_d    = 1'b0;
    retired_d = retired_q + CNT_W'(bus.pc_write);
    case (state_q)
      FETCH:   begin
        pend_d  = fetch_req && !bus.mem_ready;
        state_d = (fetch_req && bus.mem_ready) ? DECODE : FETCH;
      end
      DECODE:  state_d = legal ? EXEC : ILL;
      EXEC:    state_d = (is_br || is_jal || is_jalr) ? FETCH : (is_ld || is_st) ? MEM : WB;
      MEM:     state_d = !bus.mem_ready ? MEM : is_st ? FETCH : WB;
      WB:      state_d = FETCH;
      ILL:     state_d = ILL;
      default: state_d = FETCH;
    endcase
  end
  // a fetch request stays up until mem_ready even if run drops; every retirement coincides with pc_write
  always_comb begin
    fetch_req        = state_q == FETCH && rst_n && (bus.run || pend_q);
    bus.mem_req      = fetch_req || state_q == MEM;
    bus.mem_we       = state_q == MEM && is_st;
    bus.mem_sel_data = state_q == MEM;
    bus.ir_write     = fetch_req && bus.mem_ready;
    bus.pc_write     = (state_q == EXEC && (is_br || is_jal || is_jalr)) ||
                       (state_q == MEM && is_st && bus.mem_ready) || state_q == WB;
    bus.pc_src       = state_q != EXEC ? 2'd0 : is_jalr ? 2'd2 :
                       (is_jal || (is_br && bus.br_taken)) ? 2'd1 : 2'd0;
    bus.reg_write    = (state_q == EXEC && (is_jal || is_jalr)) || state_q == WB;
    bus.mem_to_reg   = state_q == WB && is_ld;
    bus.illegal      = state_q == ILL;
    bus.state        = state_q;
    bus.retired      = retired_q;
  end
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: scoreboarded bench; per-instruction cycle sequences are derived from the phase rules and checked by a monitor.
module tb_riscv_mc_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  riscv_mc_ctrl_if #(.CNT_W(32)) bus();
  riscv_mc_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef enum {K_BR, K_JAL, K_JALR, K_LD, K_ST, K_ALU, K_ILL} kind_e;
  typedef struct {
    logic run, rdy, br;
    logic [2:0] st;
    logic req, we, sel, irw, pcw;
    logic [1:0] src;
    logic rw, m2r, ill;
    logic [31:0] ret;
  } rec_t;
  rec_t exp_q[$];
  rec_t e;
  int checks = 0;
  int failures = 0;
  logic [31:0] model_ret = 0;
  logic [31:0] pool [9] = '{32'h00a00093, 32'h002081b3, 32'h0000a203, 32'h0040a023,
                            32'h00208463, 32'h008000ef, 32'h000080e7, 32'h000120b7, 32'h00001097};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  function automatic kind_e classify(input logic [6:0] op);
    case (op)
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return K_ALU;
      default: return K_ILL;
    endcase
  endfunction
  function automatic rec_t base(input logic [2:0] st);
    rec_t x = '{default: '0};
    x.st  = st;
    x.run = 1'($urandom);
    x.rdy = 1'($urandom);
    x.br  = 1'($urandom);
    x.ret = model_ret;
    return x;
  endfunction
  task automatic drive(input rec_t seq[$], input logic [6:0] op);
    foreach (seq[i]) exp_q.push_back(seq[i]);
    foreach (seq[i]) begin
      bus.run = seq[i].run;
      bus.mem_ready = seq[i].rdy;
      bus.br_taken = seq[i].br;
      if (seq[i].st == 3'd1) bus.opcode = op;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic idle(input int n);
    rec_t seq[$];
    rec_t x;
    for (int i = 0; i < n; i++) begin
      x = base(0);
      x.run = 1'b0;
      seq.push_back(x);
    end
    drive(seq, bus.opcode);
  endtask
  task automatic issue(input logic [31:0] ins, input logic br, input int fw, input int mw);
    rec_t seq[$];
    rec_t x;
    kind_e k = classify(ins[6:0]);
    for (int w = 0; w <= fw; w++) begin
      x = base(0);
      if (w == 0) x.run = 1'b1;
      x.rdy = (w == fw);
      x.req = 1'b1;
      x.irw = (w == fw);
      seq.push_back(x);
    end
    seq.push_back(base(1));
    if (k == K_ILL) begin
      for (int n = 0; n < 6; n++) begin
        x = base(7);
        x.ill = 1'b1;
        seq.push_back(x);
      end
    end else begin
      x = base(2);
      x.br = br;
      if (k == K_BR) begin x.pcw = 1'b1; x.src = br ? 2'd1 : 2'd0; end
      if (k == K_JAL || k == K_JALR) begin x.rw = 1'b1; x.pcw = 1'b1; x.src = (k == K_JAL) ? 2'd1 : 2'd2; end
      seq.push_back(x);
      if (x.pcw) model_ret++;
      if (k == K_LD || k == K_ST) begin
        for (int w = 0; w <= mw; w++) begin
          x = base(3);
          x.req = 1'b1;
          x.sel = 1'b1;
          x.we = (k == K_ST);
          x.rdy = (w == mw);
          x.pcw = (w == mw) && (k == K_ST);
          seq.push_back(x);
        end
        if (k == K_ST) model_ret++;
      end
      if (k == K_LD || k == K_ALU) begin
        x = base(4);
        x.rw = 1'b1;
        x.pcw = 1'b1;
        x.m2r = (k == K_LD);
        seq.push_back(x);
        model_ret++;
      end
    end
    drive(seq, ins[6:0]);
  endtask
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", 32'(bus.state), 32'(e.st));
      chk("strobes", {bus.mem_req, bus.mem_we, bus.mem_sel_data, bus.ir_write, bus.pc_write,
                      bus.pc_src, bus.reg_write, bus.mem_to_reg, bus.illegal},
                     {e.req, e.we, e.sel, e.irw, e.pcw, e.src, e.rw, e.m2r, e.ill});
      chk("retired", bus.retired, e.ret);
    end
  end
  initial begin
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    bus.br_taken = 1'b0;
    bus.opcode = 7'd0;
    #12;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_retired", bus.retired, 0);
    chk("rst_illegal", 32'(bus.illegal), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.run = 1'b0;
    @(posedge clk);
    #1;
    issue(32'h000012b7, 0, 0, 0);
    issue(32'h00128293, 0, 0, 0);
    issue(32'h00528333, 0, 0, 0);
    issue(32'h0062a023, 0, 0, 0);
    issue(32'h0002a383, 0, 0, 0);
    issue(32'h00730463, 1, 0, 0);
    chk("retired_after_24", bus.retired, 6);
    issue(32'h02000fe7, 0, 3, 0);
    issue(32'h00001c63, 0, 0, 0);
    issue(32'h001c2623, 0, 0, 2);
    idle(3);
    for (int i = 0; i < 150; i++) begin
      issue(pool[$urandom_range(0, 8)], 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    chk("retired_total", bus.retired, model_ret);
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.opcode = 7'b0000011;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_load_state", 32'(bus.state), 3);
    chk("mid_load_req", 32'(bus.mem_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(bus.state), 0);
    chk("async_rst_req", 32'(bus.mem_req), 0);
    chk("async_rst_retired", bus.retired, 0);
    model_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.run = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    chk("refetch_req", 32'(bus.mem_req), 1);
    @(posedge clk);
    #1;
    issue(32'h0000a203, 0, 1, 1);
    chk("retired_after_reset", bus.retired, 1);
    issue(32'h0000007f, 0, 1, 0);
    chk("ill_state", 32'(bus.state), 7);
    chk("ill_flag", 32'(bus.illegal), 1);
    rst_n = 1'b0;
    #1;
    chk("ill_cleared", 32'(bus.illegal), 0);
    chk("ill_rst_state", 32'(bus.state), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
